sensor_fault_monitor: RTL and testbench

//  Per-channel fault tracker that sits on the error_flags side of the sensor preprocessor (Fusion Core).

---
 rtl/sensor_fault_monitor.sv | 124 ++++++++++++
 tb/tb_sensor_fault_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_fault_monitor.sv
// rtl/sensor_fault_monitor.sv - per-channel out-of-range filter with fault mask, degraded flag and new-fault irq
module sensor_fault_monitor #(
  parameter int NUM_CH         = 16,
  parameter int CNT_W          = 4,
  parameter int FAULT_THRESH   = 4,
  parameter int RECOVER_THRESH = 8,
  parameter int DEGRADE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flags_valid,
  input  logic [NUM_CH-1:0] error_flags,
  input  logic [NUM_CH-1:0] clear_fault,
  output logic [NUM_CH-1:0] fault_mask,
  output logic [4:0]        fault_count,
  output logic              degraded,
  output logic              fault_irq
);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT, ST_RECOVER} ch_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] FT      = CNT_W'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] RT      = CNT_W'(RECOVER_THRESH);

  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] mask_d;
  logic [4:0]        count_d;
  logic              degraded_d;
  logic              irq_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OK;
        cnt_q[i]   <= '0;
      end
      fault_mask  <= '0;
      fault_count <= '0;
      degraded    <= 1'b0;
      fault_irq   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      fault_mask  <= mask_d;
      fault_count <= count_d;
      degraded    <= degraded_d;
      fault_irq   <= irq_d;
    end
  end

  always_comb begin
    irq_d   = 1'b0;
    mask_d  = '0;
    count_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear_fault[i]) begin
        state_d[i] = ST_OK;
        cnt_d[i]   = '0;
      end else if (flags_valid) begin
        unique case (state_q[i])
          ST_OK: begin
            if (error_flags[i]) begin
              cnt_d[i]   = CNT_ONE;
              state_d[i] = (FT == CNT_ONE) ? ST_FAULT : ST_SUSPECT;
            end else begin
              cnt_d[i] = '0;
            end
          end
          ST_SUSPECT: begin
            if (error_flags[i]) begin
              cnt_d[i] = sat_inc(cnt_q[i]);
              if (sat_inc(cnt_q[i]) == FT) state_d[i] = ST_FAULT;
            end else begin
              state_d[i] = ST_OK;
              cnt_d[i]   = '0;
            end
          end
          ST_FAULT: begin
            if (error_flags[i]) begin
              cnt_d[i] = '0;
            end else if (RT == CNT_ONE) begin
              state_d[i] = ST_OK;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = ST_RECOVER;
              cnt_d[i]   = CNT_ONE;
            end
          end
          ST_RECOVER: begin
            if (error_flags[i]) begin
              state_d[i] = ST_FAULT;
              cnt_d[i]   = '0;
            end else if (sat_inc(cnt_q[i]) == RT) begin
              state_d[i] = ST_OK;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
        endcase
        // Relapse from RECOVER is not a new fault, so only OK/SUSPECT entries raise the irq.
        if ((state_q[i] == ST_OK || state_q[i] == ST_SUSPECT) && state_d[i] == ST_FAULT)
          irq_d = 1'b1;
      end
      mask_d[i] = (state_d[i] == ST_FAULT) || (state_d[i] == ST_RECOVER);
      count_d   = count_d + 5'(mask_d[i]);
    end
    degraded_d = (count_d >= 5'(DEGRADE_LIMIT));
  end

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// tb/tb_sensor_fault_monitor.sv - directed and randomized checks against a run-length reference model
module tb_sensor_fault_monitor;

  localparam int FT = 4;
  localparam int RT = 8;
  localparam int DL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flags_valid = 1'b0;
  logic [15:0] error_flags = '0;
  logic [15:0] clear_fault = '0;
  logic [15:0] fault_mask;
  logic [4:0]  fault_count;
  logic        degraded;
  logic        fault_irq;

  sensor_fault_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .flags_valid (flags_valid),
    .error_flags (error_flags),
    .clear_fault (clear_fault),
    .fault_mask  (fault_mask),
    .fault_count (fault_count),
    .degraded    (degraded),
    .fault_irq   (fault_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel is faulty after FT flagged frames in a row and healthy again after RT clean ones.
  int          bad_run  [16];
  int          good_run [16];
  bit          faulted  [16];
  logic [15:0] m_mask = '0;
  logic        m_irq  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        bad_run[i] = 0; good_run[i] = 0; faulted[i] = 1'b0;
      end
      m_mask = '0;
      m_irq  = 1'b0;
    end else begin
      m_irq = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (clear_fault[i]) begin
          faulted[i] = 1'b0; bad_run[i] = 0; good_run[i] = 0;
        end else if (flags_valid) begin
          if (!faulted[i]) begin
            if (error_flags[i]) begin
              bad_run[i]++;
              if (bad_run[i] >= FT) begin
                faulted[i] = 1'b1; good_run[i] = 0; m_irq = 1'b1;
              end
            end else begin
              bad_run[i] = 0;
            end
          end else if (error_flags[i]) begin
            good_run[i] = 0;
          end else begin
            good_run[i]++;
            if (good_run[i] >= RT) begin
              faulted[i] = 1'b0; bad_run[i] = 0; good_run[i] = 0;
            end
          end
        end
        m_mask[i] = faulted[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mask", 32'(fault_mask), 32'(m_mask));
      check("cyc_count", 32'(fault_count), 32'($countones(m_mask)));
      check("cyc_degraded", 32'(degraded), 32'($countones(m_mask) >= DL));
      check("cyc_irq", 32'(fault_irq), 32'(m_irq));
    end
  end

  task automatic frame(input logic [15:0] f, input logic [15:0] clr);
    @(posedge clk); #1;
    flags_valid = 1'b1; error_flags = f; clear_fault = clr;
  endtask

  task automatic idle(input logic [15:0] f);
    @(posedge clk); #1;
    flags_valid = 1'b0; error_flags = f; clear_fault = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; flags_valid = 1'b0; clear_fault = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [15:0] bad_set;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_mask", 32'(fault_mask), 32'h0);
    check("rst_count", 32'(fault_count), 32'h0);

    // Async reset with ch3 in FAULT, then only 3 flagged frames
    repeat (4) frame(16'h0008, '0);
    idle('0);
    check("t1_mask_pre", 32'(fault_mask), 32'h0008);
    #2 rst = 1'b1;
    #1;
    check("t1_mask_rst", 32'(fault_mask), 32'h0);
    check("t1_count_rst", 32'(fault_count), 32'h0);
    check("t1_irq_rst", 32'(fault_irq), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) frame(16'h0008, '0);
    idle('0);
    check("t1_suspect_only", 32'(fault_mask), 32'h0);

    // Fault entry, single irq pulse
    do_reset();
    repeat (4) frame(16'h0001, '0);
    idle('0);
    check("t2_mask", 32'(fault_mask), 32'h0001);
    check("t2_count", 32'(fault_count), 32'h1);
    check("t2_irq", 32'(fault_irq), 32'h1);
    idle('0);
    check("t2_irq_once", 32'(fault_irq), 32'h0);
    do_reset();
    repeat (3) frame(16'h0001, '0);
    frame(16'h0000, '0);
    repeat (3) frame(16'h0001, '0);
    idle('0);
    check("t2_broken_run", 32'(fault_mask), 32'h0);

    // Recovery needs 8 clean frames in a row
    do_reset();
    repeat (4) frame(16'h0001, '0);
    repeat (7) frame(16'h0000, '0);
    frame(16'h0001, '0);
    idle('0);
    check("t3_relapse_mask", 32'(fault_mask), 32'h0001);
    check("t3_relapse_irq", 32'(fault_irq), 32'h0);
    repeat (7) frame(16'h0000, '0);
    frame(16'h0000, '0);
    check("t3_before_8th", 32'(fault_mask), 32'h0001);
    idle('0);
    check("t3_recovered", 32'(fault_mask), 32'h0);

    // Idle gaps do not break a run; flags ignored while invalid
    do_reset();
    frame(16'h0001, '0); idle(16'hFFFF); idle(16'h5A5A);
    frame(16'h0001, '0); idle(16'h0000);
    frame(16'h0001, '0); idle(16'hFFFF); idle(16'h1234); idle(16'hFFFF);
    frame(16'h0001, '0); idle(16'hFFFF);
    check("t4_mask", 32'(fault_mask), 32'h0001);
    check("t4_irq", 32'(fault_irq), 32'h1);
    repeat (5) idle(16'(($urandom)));
    check("t4_hold", 32'(fault_mask), 32'h0001);

    // Simultaneous faults and degraded mode
    do_reset();
    repeat (4) frame(16'h000F, '0);
    idle('0);
    check("t5_count4", 32'(fault_count), 32'h4);
    check("t5_degraded", 32'(degraded), 32'h1);
    check("t5_irq", 32'(fault_irq), 32'h1);
    idle('0);
    check("t5_irq_once", 32'(fault_irq), 32'h0);
    repeat (4) frame(16'hFFFF, '0);
    idle('0);
    check("t5_count16", 32'(fault_count), 32'h10);
    check("t5_mask_all", 32'(fault_mask), 32'hFFFF);

    // Clear beats a flag in the same cycle
    do_reset();
    repeat (4) frame(16'h0020, '0);
    idle('0);
    check("t6_mask_pre", 32'(fault_mask), 32'h0020);
    frame(16'h0020, 16'h0020);
    idle('0);
    check("t6_cleared", 32'(fault_mask), 32'h0);
    check("t6_no_irq", 32'(fault_irq), 32'h0);
    repeat (3) frame(16'h0020, '0);
    idle('0);
    check("t6_cnt_zero", 32'(fault_mask), 32'h0);
    do_reset();
    repeat (3) frame(16'h0020, '0);
    frame(16'h0020, 16'h0020);
    idle('0);
    check("t6_suppress_irq", 32'(fault_irq), 32'h0);

    // Randomized run with sticky bad channels, sporadic clears and resets
    do_reset();
    bad_set = 16'($urandom) & 16'($urandom);
    for (int n = 0; n < 4000; n++) begin
      if (n % 150 == 0) bad_set = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        idle(16'($urandom));
      end else begin
        frame(bad_set ^ (16'($urandom) & 16'($urandom) & 16'($urandom)),
              ($urandom_range(0, 39) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0);
      end
    end
    idle('0);
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
